// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op codes, FSM state encoding, op-code width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0111;
    localparam logic [OP_W-1:0] OP_DIV = 4'b1000;

    // ST_DONE keeps the legacy encoding slot; FIX hands straight back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Shared iterative unsigned multiplier / restoring divider on one adder.
// Latency: WIDTH cycles after start; done is high during the final step.
// Backpressure: none; once started it runs to completion (or reset).
//
// Ports: start/is_div/mag_a/mag_b load a new job; done flags the last step;
//        acc_hi/acc_lo hold {product} or {remainder, quotient} afterwards.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic             done,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   alu_w;

    // One W+1 bit adder serves both algorithms: add multiplicand for MUL,
    // trial-subtract divisor from the shifted partial remainder for DIV.
    always_comb begin
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        if (div_q) begin
            alu_w = rem_sh - {1'b0, opb_q};
        end else begin
            alu_w = {1'b0, hi_q} + {1'b0, opb_q};
        end
    end

    assign done   = busy_q && (cnt_q == CNT_W'(1));
    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
        end else if (start) begin
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
            div_q  <= is_div;
            hi_q   <= '0;
            lo_q   <= mag_a;
            opb_q  <= mag_b;
        end else if (busy_q) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
            if (div_q) begin
                // Top bit of the trial result set means it went negative:
                // keep (restore) the shifted remainder and shift in a 0.
                if (!alu_w[WIDTH]) begin
                    hi_q <= alu_w[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= rem_sh[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end else if (lo_q[0]) begin
                hi_q <= alu_w[WIDTH:1];
                lo_q <= {alu_w[0], lo_q[WIDTH-1:1]};
            end else begin
                hi_q <= {1'b0, hi_q[WIDTH-1:1]};
                lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; iterative MUL/DIV/REM.
// Latency: 1 cycle for logic/add/sub/slt/special DIV/illegal; WIDTH+2 for MUL/DIV.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready low until drained.
//
// Ports: in_valid/in_ready + a, b, op, unsig form the request; out_valid/out_ready
//        + result, result_hi, compout, overflow, div_by_zero, illegal_op the response.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             unsig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             compout,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic             accept;
    logic             multi;

    logic             sign_a;
    logic             sign_b;
    logic             lt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic             b_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_dbz;
    logic             sc_ill;

    // Context of the in-flight MUL/DIV, captured at accept.
    logic             p_div_q;
    logic             p_unsig_q;
    logic             p_cmp_q;
    logic             neg_q;
    logic             rneg_q;

    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fx_res;
    logic [WIDTH-1:0]   fx_hi;
    logic               fx_ovf;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             compout_q;
    logic             overflow_q;
    logic             dbz_q;
    logic             ill_q;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign sign_a  = a[WIDTH-1];
    assign sign_b  = b[WIDTH-1];
    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = {1'b0, a} - {1'b0, b};
    assign lt      = unsig ? (a < b) : ($signed(a) < $signed(b));
    assign b_zero  = (b == '0);
    assign div_ovf = !unsig && (a == SMIN) && (b == '1);
    // Signed MIN maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign mag_a   = (!unsig && sign_a) ? -a : a;
    assign mag_b   = (!unsig && sign_b) ? -b : b;

    assign multi = (op == OP_MUL) || ((op == OP_DIV) && !b_zero && !div_ovf);

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_ovf = unsig ? add_w[WIDTH]
                               : ((sign_a == sign_b) && (add_w[WIDTH-1] != sign_a));
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR: sc_res = ~(a | b);
            OP_XOR: sc_res = a ^ b;
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                // sub_w[WIDTH] is the borrow, i.e. unsigned a < b.
                sc_ovf = unsig ? sub_w[WIDTH]
                               : ((sign_a != sign_b) && (sub_w[WIDTH-1] != sign_a));
            end
            OP_MUL: begin
                // Handled by the iterator; nothing loads from here.
            end
            OP_DIV: begin
                if (b_zero) begin
                    sc_res = '1;
                    sc_hi  = a;
                    sc_dbz = 1'b1;
                end else if (div_ovf) begin
                    sc_res = SMIN;
                    sc_ovf = 1'b1;
                end
            end
            default: sc_ill = 1'b1;
        endcase
    end

    alu_seq_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && multi),
        .is_div (op == OP_DIV),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .done   (md_done),
        .acc_hi (md_hi),
        .acc_lo (md_lo)
    );

    // Sign correction of the magnitude result. MUL negates the full 2W product;
    // DIV negates quotient and remainder independently (remainder follows a).
    always_comb begin
        prod_s = neg_q ? -{md_hi, md_lo} : {md_hi, md_lo};
        fx_res = '0;
        fx_hi  = '0;
        fx_ovf = 1'b0;
        if (p_div_q) begin
            fx_res = neg_q  ? -md_lo : md_lo;
            fx_hi  = rneg_q ? -md_hi : md_hi;
        end else begin
            fx_res = prod_s[WIDTH-1:0];
            fx_hi  = prod_s[2*WIDTH-1:WIDTH];
            fx_ovf = p_unsig_q ? (fx_hi != '0)
                               : (fx_hi != {WIDTH{prod_s[WIDTH-1]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p_div_q     <= 1'b0;
            p_unsig_q   <= 1'b0;
            p_cmp_q     <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            compout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && multi) begin
                        state_q <= (op == OP_MUL) ? ST_MUL : ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (accept && multi) begin
                p_div_q   <= (op == OP_DIV);
                p_unsig_q <= unsig;
                p_cmp_q   <= lt;
                neg_q     <= !unsig && (sign_a ^ sign_b);
                rneg_q    <= !unsig && sign_a;
            end

            if (accept && !multi) begin
                out_valid_q <= 1'b1;
                result_q    <= sc_res;
                result_hi_q <= sc_hi;
                compout_q   <= lt;
                overflow_q  <= sc_ovf;
                dbz_q       <= sc_dbz;
                ill_q       <= sc_ill;
            end else if (state_q == ST_FIX) begin
                out_valid_q <= 1'b1;
                result_q    <= fx_res;
                result_hi_q <= fx_hi;
                compout_q   <= p_cmp_q;
                overflow_q  <= fx_ovf;
                dbz_q       <= 1'b0;
                ill_q       <= 1'b0;
            end else if (out_ready) begin
                // Drained with nothing new: drop valid, flags keep last values.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign compout     = compout_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    op;
    logic          unsig;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          compout;
    logic          overflow;
    logic          div_by_zero;
    logic          illegal_op;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .unsig       (unsig),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .compout     (compout),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cmp;
        logic         ovf;
        logic         dbz;
        logic         ill;
        int           lat;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         u;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cmp;
        logic         ovf;
        logic         dbz;
        logic         ill;
        int           lat;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic u);
        exp_t e;
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        longint s;
        longint unsigned up;
        e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
        e.cmp = u ? (ux < uy) : (sx < sy);
        case (o)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_XOR: e.res = x ^ y;
            OP_NOR: e.res = ~(x | y);
            OP_SLT: e.res = {31'b0, e.cmp};
            OP_ADD: begin
                e.res = x + y;
                s = sx + sy;
                e.ovf = u ? ((ux + uy) > 64'hFFFF_FFFF) : (s > SMAX || s < SMIN);
            end
            OP_SUB: begin
                e.res = x - y;
                s = sx - sy;
                e.ovf = u ? (ux < uy) : (s > SMAX || s < SMIN);
            end
            OP_MUL: begin
                e.lat = 34;
                if (u) begin
                    up = ux * uy;
                    e.res = up[31:0]; e.hi = up[63:32];
                    e.ovf = (e.hi != 0);
                end else begin
                    s = sx * sy;
                    e.res = s[31:0]; e.hi = s[63:32];
                    e.ovf = (s > SMAX || s < SMIN);
                end
            end
            OP_DIV: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.dbz = 1'b1;
                end else if (!u && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.res = 32'h8000_0000; e.ovf = 1'b1;
                end else begin
                    e.lat = 34;
                    if (u) begin
                        up = ux / uy; e.res = up[31:0];
                        up = ux % uy; e.hi  = up[31:0];
                    end else begin
                        s = sx / sy; e.res = s[31:0];
                        s = sx % sy; e.hi  = s[31:0];
                    end
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Present a request, wait for accept, then scramble inputs and measure
    // cycles until out_valid (1 = result visible in the cycle after accept).
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic u, output int lat);
        int waitc = 0;
        @(negedge clk);
        op = o; a = x; b = y; unsig = u; in_valid = 1'b1;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waitc);
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom); unsig = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e, input int lat);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".lat"},   64'(lat),       64'(e.lat));
        chk({tag, ".res"},   64'(result),    64'(e.res));
        chk({tag, ".hi"},    64'(result_hi), 64'(e.hi));
        chk({tag, ".cmp"},   64'(compout),   64'(e.cmp));
        chk({tag, ".ovf"},   64'(overflow),  64'(e.ovf));
        chk({tag, ".dbz"},   64'(div_by_zero), 64'(e.dbz));
        chk({tag, ".ill"},   64'(illegal_op),  64'(e.ill));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vt[17];

    initial begin
        int   lat;
        int   seen;
        exp_t e;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        logic ru;

        vt[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[1]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[2]  = '{OP_NOR, 32'h0F0F_0000, 32'h00F0_0000, 1'b0, 32'hF000_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[3]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[4]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[5]  = '{OP_MUL, 32'hFFFF_FFFD, 32'h7, 1'b0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 34};
        vt[6]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 34};
        vt[7]  = '{OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 34};
        vt[8]  = '{OP_DIV, 32'h5, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[9]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[10] = '{OP_SUB, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[11] = '{OP_SUB, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[12] = '{4'hC, 32'h1234_5678, 32'h1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vt[13] = '{OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 32'h0000_0FF0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[14] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 34};
        vt[15] = '{OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 34};
        vt[16] = '{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 34};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; unsig = 1'b0;
        #1;
        chk("reset.valid", 64'(out_valid), 64'(0));
        chk("reset.res",   64'(result),    64'(0));
        chk("reset.hi",    64'(result_hi), 64'(0));
        chk("reset.flags", 64'({compout, overflow, div_by_zero, illegal_op}), 64'(0));
        chk("reset.in_ready", 64'(in_ready), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].u, lat);
            e = '{vt[i].res, vt[i].hi, vt[i].cmp, vt[i].ovf, vt[i].dbz, vt[i].ill, vt[i].lat};
            chk_out($sformatf("vec%0d", i), e, lat);
        end

        // Randomized against the reference model
        for (int n = 0; n < 200; n++) begin
            ro = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ra = pick(); rb = pick(); ru = 1'($urandom);
            run_op(ro, ra, rb, ru, lat);
            chk_out($sformatf("rnd%0d(op%0d a=%0h b=%0h u=%0d)", n, ro, ra, rb, ru), model(ro, ra, rb, ru), lat);
        end

        // Backpressure: result held, no accept until drained
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        run_op(OP_ADD, 32'd5, 32'd6, 1'b0, lat);
        chk("bp.lat", 64'(lat), 64'(1));
        chk("bp.res", 64'(result), 64'(11));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.in_ready", 64'(in_ready), 64'(0));
            chk("bp.valid", 64'(out_valid), 64'(1));
            chk("bp.res_hold", 64'(result), 64'(11));
        end
        // Drain and accept in the same cycle
        @(negedge clk);
        out_ready = 1'b1; op = OP_ADD; a = 32'd100; b = 32'd23; unsig = 1'b0; in_valid = 1'b1;
        #1;
        chk("b2b.in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b.valid", 64'(out_valid), 64'(1));
        chk("b2b.res", 64'(result), 64'(123));

        // Reset in the middle of a MUL
        @(negedge clk);
        op = OP_MUL; a = 32'd1000; b = 32'd3; unsig = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", 64'(out_valid), 64'(0));
        chk("rst_mid.res",   64'(result),    64'(0));
        chk("rst_mid.flags", 64'({compout, overflow, div_by_zero, illegal_op}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_mid.no_result", 64'(seen), 64'(0));
        run_op(OP_OR, 32'd1, 32'd2, 1'b0, lat);
        chk_out("post_rst_or", model(OP_OR, 32'd1, 32'd2, 1'b0), lat);
        chk("post_rst_or.res3", 64'(result), 64'(3));
        run_op(4'hF, 32'hDEAD, 32'hBEEF, 1'b0, lat);
        chk("illegal.flag", 64'(illegal_op), 64'(1));
        chk("illegal.res",  64'(result), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Adds valid/ready handshaking on both sides, a WIDTH parameter, correct NOR, signed/unsigned overflow, and multi-cycle iterative MUL and DIV/REM on a shared datapath.
- Sits between the decode/issue stage and writeback in the datapath; one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block accepts a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation code (see Behaviour)
- unsig  in  1  1 = unsigned interpretation, 0 = two's complement
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  primary result (MUL low half, DIV quotient)
- result_hi  out  WIDTH  MUL high half, DIV remainder, else 0
- compout  out  1  a<b under unsig, updated for every op
- overflow  out  1  overflow flag for ADD/SUB/MUL/DIV, else 0
- div_by_zero  out  1  DIV issued with b==0
- illegal_op  out  1  unsupported op code

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, result, result_hi, compout, overflow, div_by_zero, illegal_op all 0; counter 0.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (result = zero-extended compout)
  - 0100 NOR (~(a|b), bitwise), 0101 XOR, 0110 SUB, 0111 MUL, 1000 DIV
  - all other codes are illegal.
- Accept: a request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready); a same-cycle drain plus accept is legal.
  - Operands, op and unsig are captured at accept; later changes on the inputs are ignored.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE + accept of a single-cycle op or illegal op: results are registered, out_valid=1 next cycle (latency 1), state stays IDLE.
  - IDLE + accept MUL: operand magnitudes are latched, counter=WIDTH, go to MUL. Each cycle does one shift-add step and decrements the counter. At 0, go to FIX.
  - IDLE + accept DIV with b!=0 (and not the signed MIN/-1 case): go to DIV. Restoring division, one quotient bit per cycle, WIDTH cycles, then go to FIX.
  - FIX: applies sign correction to signed MUL/DIV, loads the output registers, sets out_valid=1, then goes to IDLE.
  - Total MUL/DIV latency from accept to out_valid: WIDTH+2 cycles.
- DIV special cases, resolved at accept with latency 1:
  - b==0: result = all ones, result_hi = a, div_by_zero=1.
  - Signed MIN / -1: result = MIN, result_hi = 0, overflow=1.
- Signed DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow rules:
  - ADD signed: operand signs equal and result sign differs. ADD unsigned: carry out of the MSB.
  - SUB signed: operand signs differ and result sign differs from a. SUB unsigned: borrow (a<b).
  - MUL unsigned: result_hi != 0. MUL signed: result_hi is not the sign-extension of result[WIDTH-1].
  - Logic ops, SLT, illegal: overflow = 0.
- Illegal op: result=0, result_hi=0, illegal_op=1, latency 1.
- Output hold: all outputs stay stable while out_valid && !out_ready. When out_ready is seen with no new completion, out_valid drops next cycle. Flags hold their last values.
- Reset mid-operation: any MUL/DIV in flight is abandoned, no result is produced, and outputs return to their reset values immediately.

Decomposition:
- Package alu_seq_pkg holds:
  - op code localparams (OP_AND … OP_DIV)
  - the FSM state enum
  - the OP_W=4 constant
- Sub-module alu_seq_muldiv: the shared shift-add/restoring-subtract iterator with start, done, and the counter.
- The top level keeps the handshake, the single-cycle ops, special-case detection, and output registers.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1, unsig=0 -> result 0x80000000, overflow=1, out_valid one cycle after accept. Same operands with unsig=1 -> overflow=0.
- NOR a=0x0F0F0000, b=0x00F00000 -> result 0xF000FFFF, overflow=0. SLT a=0xFFFFFFFF, b=1: unsig=0 -> result 1; unsig=1 -> result 0.
- MUL signed a=-3, b=7 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, overflow=0, out_valid exactly 34 cycles after accept. MUL unsigned 0x10000×0x10000 -> result 0, result_hi 1, overflow=1.
- DIV signed a=-7, b=2 -> result 0xFFFFFFFD, result_hi 0xFFFFFFFF. DIV a=5, b=0 -> result 0xFFFFFFFF, result_hi 5, div_by_zero=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD completes -> in_ready=0 and outputs stable. Assert out_ready together with a new in_valid -> back-to-back accept, next result one cycle later.
- Drop rst_n mid-MUL (cycle 10) -> out_valid=0 immediately. After release, an OR a=1, b=2 -> result 3. op=1111 -> illegal_op=1, result 0.
